stream_demux: RTL and testbench

- 1:N stream demultiplexer: routes each accepted input beat to one of N_OUT output channels. Companion to the 2:1 selector in the data-path library.
- Each output channel has a one-entry registered slot with a valid/ready handshake.
- The channel is chosen either by an explicit per-beat select or by an internal round-robin pointer.
- Sits between a single producer and N independent consumers, e.g. distributing a shared bus to parallel lanes.

---
 rtl/stream_demux_pkg.sv | 32 +++
 rtl/stream_demux_slot.sv | 46 ++++
 rtl/stream_demux.sv | 120 ++++++++++++
 tb/tb_stream_demux.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demux and sibling lane blocks:
// select-width helper, channel-slice macro and the per-beat route type.
`ifndef STREAM_DEMUX_PKG_SV
`define STREAM_DEMUX_PKG_SV

// Part-select for lane k of a flat bus built from equal W-bit lanes.
`define SD_SLICE(k, w) ((k) * (w)) +: (w)

package stream_demux_pkg;

  localparam int unsigned N_OUT_MIN = 2;
  localparam int unsigned N_OUT_MAX = 16;

  // Minimum select width able to address n channels (never below 1 bit).
  function automatic int unsigned sel_w_for(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  // What happens to the beat presented on the input this cycle.
  typedef enum logic [1:0] {
    ROUTE_IDLE  = 2'd0,  // no beat offered
    ROUTE_LOAD  = 2'd1,  // accepted into an in-range slot
    ROUTE_DROP  = 2'd2,  // accepted and discarded, select out of range
    ROUTE_STALL = 2'd3   // destination slot full and its consumer stalled
  } route_e;

endpackage

`endif

// File: rtl/stream_demux_slot.sv
// One-entry output slot: loads a beat, holds it stable under backpressure,
// and accepts a replacement in the same cycle it drains (full throughput).
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         can_load
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: a load wins over a drain so the slot stays full on overlap.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    can_load = ~valid_q | out_ready;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers; reset discards any held beat without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// 1:N stream demultiplexer. Each accepted beat goes to the channel picked by
// in_sel (explicit mode) or by a round-robin pointer (auto mode).
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; ready never depends on valid, and a producer holding valid keeps its
// data stable until the transfer. The same rule applies on every output lane.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_OUT = 2,
  parameter int SEL_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               auto_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic [SEL_W-1:0]   rr_ptr,
  output logic               err_sel
);

  if ((N_OUT < N_OUT_MIN) || (N_OUT > N_OUT_MAX) ||
      (SEL_W < int'(sel_w_for(N_OUT)))) begin : g_bad_params
    $error("stream_demux: N_OUT must be 2..16 and SEL_W >= clog2(N_OUT)");
  end

  // Channel count and last pointer value in select-sized arithmetic.
  localparam logic [SEL_W:0]   N_OUT_X  = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_sel_q, err_sel_d;
  logic [SEL_W-1:0] dest;
  logic             dest_ok;
  logic             dest_free;
  logic [N_OUT-1:0] can_load;
  logic [N_OUT-1:0] load;
  route_e           route;

  // Destination, range check and the ready seen by the producer.
  always_comb begin
    dest      = auto_mode ? rr_ptr_q : in_sel;
    dest_ok   = ({1'b0, dest} < N_OUT_X);
    dest_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (dest == SEL_W'(k)) begin
        dest_free = can_load[k];
      end
    end
    // Out-of-range beats are always swallowed so the producer never hangs.
    in_ready = dest_ok ? dest_free : 1'b1;
  end

  // Classify the offered beat and decode the slot load strobes.
  always_comb begin
    route = ROUTE_IDLE;
    load  = '0;
    if (in_valid) begin
      if (!dest_ok) begin
        route = ROUTE_DROP;
      end else if (dest_free) begin
        route = ROUTE_LOAD;
      end else begin
        route = ROUTE_STALL;
      end
    end
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = (route == ROUTE_LOAD) && (dest == SEL_W'(k));
    end
  end

  // Pointer moves only on an auto-mode accept and wraps at N_OUT, not 2^SEL_W;
  // the error flag is sticky until reset.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    err_sel_d = err_sel_q;
    if (auto_mode && (route == ROUTE_LOAD)) begin
      rr_ptr_d = (rr_ptr_q == LAST_PTR) ? '0 : rr_ptr_q + SEL_W'(1);
    end
    if (route == ROUTE_DROP) begin
      err_sel_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      err_sel_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      err_sel_q <= err_sel_d;
    end
  end

  assign rr_ptr  = rr_ptr_q;
  assign err_sel = err_sel_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .W(W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[`SD_SLICE(k, W)]),
      .can_load  (can_load[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 2-channel instance driven from a vector table and
// a 3-channel instance covering out-of-range selects and random traffic.
module tb_stream_demux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 2-channel instance (a_*) ----------------
  logic        a_auto, a_vld, a_ir, a_err;
  logic [0:0]  a_sel, a_rr;
  logic [7:0]  a_data;
  logic [1:0]  a_rdy, a_ov;
  logic [15:0] a_od;

  stream_demux #(.W(8), .N_OUT(2), .SEL_W(1)) dut2 (
    .clk(clk), .rst(rst), .auto_mode(a_auto), .in_valid(a_vld),
    .in_ready(a_ir), .in_data(a_data), .in_sel(a_sel), .out_valid(a_ov),
    .out_ready(a_rdy), .out_data(a_od), .rr_ptr(a_rr), .err_sel(a_err)
  );

  // ---------------- 3-channel instance (b_*) ----------------
  logic        b_auto, b_vld, b_ir, b_err;
  logic [1:0]  b_sel, b_rr;
  logic [7:0]  b_data;
  logic [2:0]  b_rdy, b_ov;
  logic [23:0] b_od;

  stream_demux #(.W(8), .N_OUT(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .auto_mode(b_auto), .in_valid(b_vld),
    .in_ready(b_ir), .in_data(b_data), .in_sel(b_sel), .out_valid(b_ov),
    .out_ready(b_rdy), .out_data(b_od), .rr_ptr(b_rr), .err_sel(b_err)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- vector table for the 2-channel instance ----------------
  // Inputs are applied for one cycle; expectations describe what is visible
  // during that cycle (in_ready for these inputs, registered outputs from
  // earlier cycles). Data is checked only on lanes expected valid.
  typedef struct packed {
    logic       rst;
    logic       au;
    logic       v;
    logic       sel;
    logic [7:0] data;
    logic [1:0] rdy;
    logic       e_ir;
    logic [1:0] e_ov;
    logic [7:0] e_d1;
    logic [7:0] e_d0;
    logic       e_rr;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, input logic au, input logic v, input logic s,
                              input logic [7:0] d, input logic [1:0] rdy, input logic ir,
                              input logic [1:0] ov, input logic [7:0] d1, input logic [7:0] d0,
                              input logic rr);
    vec_t x;
    x.rst = r; x.au = au; x.v = v; x.sel = s; x.data = d; x.rdy = rdy;
    x.e_ir = ir; x.e_ov = ov; x.e_d1 = d1; x.e_d0 = d0; x.e_rr = rr;
    return x;
  endfunction

  task automatic fill_table();
    //               rst au v sel data   rdy    ir ov     d1     d0     rr
    // explicit send to ch1, one-cycle latency, then drain
    tbl[0]  = mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 0, 1, 1, 8'hA5, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 2'b10, 8'hA5, 8'h00, 0);
    tbl[3]  = mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    // backpressure on ch0, then drain + load in the same cycle
    tbl[4]  = mk(0, 0, 1, 0, 8'h11, 2'b10, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[5]  = mk(0, 0, 1, 0, 8'h22, 2'b10, 0, 2'b01, 8'h00, 8'h11, 0);
    tbl[6]  = mk(0, 0, 1, 0, 8'h22, 2'b10, 0, 2'b01, 8'h00, 8'h11, 0);
    tbl[7]  = mk(0, 0, 1, 0, 8'h22, 2'b11, 1, 2'b01, 8'h00, 8'h11, 0);
    tbl[8]  = mk(0, 0, 0, 0, 8'h00, 2'b10, 0, 2'b01, 8'h00, 8'h22, 0);
    // ch0 stalled, ch1 still usable
    tbl[9]  = mk(0, 0, 1, 1, 8'h33, 2'b10, 1, 2'b01, 8'h00, 8'h22, 0);
    tbl[10] = mk(0, 0, 0, 1, 8'h00, 2'b00, 0, 2'b11, 8'h33, 8'h22, 0);
    tbl[11] = mk(0, 0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 8'h33, 8'h22, 0);
    // reset with both slots full and stalled, then normal delivery
    tbl[12] = mk(1, 0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 8'h33, 8'h22, 0);
    tbl[13] = mk(0, 0, 0, 0, 8'h00, 2'b00, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[14] = mk(0, 0, 1, 0, 8'h5A, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[15] = mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 2'b01, 8'h00, 8'h5A, 0);
    // auto mode, back-to-back beats, pointer 0,1,0,1,0
    tbl[16] = mk(0, 1, 1, 0, 8'h01, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[17] = mk(0, 1, 1, 0, 8'h02, 2'b11, 1, 2'b01, 8'h00, 8'h01, 1);
    tbl[18] = mk(0, 1, 1, 0, 8'h03, 2'b11, 1, 2'b10, 8'h02, 8'h00, 0);
    tbl[19] = mk(0, 1, 1, 0, 8'h04, 2'b11, 1, 2'b01, 8'h00, 8'h03, 1);
    tbl[20] = mk(0, 1, 0, 0, 8'h00, 2'b11, 1, 2'b10, 8'h04, 8'h00, 0);
    tbl[21] = mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    // pointer holds in explicit mode and survives mode toggles
    tbl[22] = mk(0, 1, 1, 0, 8'h44, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[23] = mk(0, 0, 1, 0, 8'h55, 2'b11, 1, 2'b01, 8'h00, 8'h44, 1);
    tbl[24] = mk(0, 1, 0, 0, 8'h00, 2'b11, 1, 2'b01, 8'h00, 8'h55, 1);
    tbl[25] = mk(0, 1, 1, 0, 8'h66, 2'b11, 1, 2'b00, 8'h00, 8'h00, 1);
    tbl[26] = mk(0, 0, 0, 0, 8'h00, 2'b11, 1, 2'b10, 8'h66, 8'h00, 0);
    // reset returns a non-zero pointer to 0
    tbl[27] = mk(0, 1, 1, 0, 8'h77, 2'b00, 1, 2'b00, 8'h00, 8'h00, 0);
    tbl[28] = mk(1, 0, 0, 0, 8'h00, 2'b00, 0, 2'b01, 8'h00, 8'h77, 1);
    tbl[29] = mk(0, 0, 0, 0, 8'h00, 2'b00, 1, 2'b00, 8'h00, 8'h00, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic au, input logic v, input logic s,
                         input logic [7:0] d, input logic [1:0] rdy);
    a_auto = au; a_vld = v; a_sel = s; a_data = d; a_rdy = rdy;
  endtask

  task automatic drive_b(input logic au, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [2:0] rdy);
    b_auto = au; b_vld = v; b_sel = s; b_data = d; b_rdy = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for the 3-channel instance ----------------
  // Each lane is a one-deep buffer: full flag plus data. A beat fits when the
  // lane is empty or its consumer takes the old beat in the same cycle.
  localparam int NB = 3;
  logic       m_full[NB];
  logic [7:0] m_data[NB];
  int         m_ptr;
  logic       m_err;

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 8'h00;
    end
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic e_ir;
    int   dest;

    drive_a(0, 0, 0, 8'h00, 2'b00);
    drive_b(0, 0, 2'd0, 8'h00, 3'b000);
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // reset state of both instances
    @(negedge clk);
    chk("a_reset_out_valid", a_ov, 2'b00);
    chk("a_reset_out_data", a_od, 16'h0000);
    chk("a_reset_rr_ptr", a_rr, 1'b0);
    chk("a_reset_err_sel", a_err, 1'b0);
    chk("b_reset_out_valid", b_ov, 3'b000);
    chk("b_reset_out_data", b_od, 24'h000000);
    chk("b_reset_err_sel", b_err, 1'b0);
    chk("b_reset_in_ready", b_ir, 1'b1);
    next_cycle();

    // table-driven vectors on the 2-channel instance
    fill_table();
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst;
      drive_a(tbl[i].au, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("a_in_ready[%0d]", i), a_ir, tbl[i].e_ir);
      chk($sformatf("a_out_valid[%0d]", i), a_ov, tbl[i].e_ov);
      chk($sformatf("a_rr_ptr[%0d]", i), a_rr, tbl[i].e_rr);
      chk($sformatf("a_err_sel[%0d]", i), a_err, 1'b0);
      if (tbl[i].e_ov[0]) chk($sformatf("a_data0[%0d]", i), a_od[7:0], tbl[i].e_d0);
      if (tbl[i].e_ov[1]) chk($sformatf("a_data1[%0d]", i), a_od[15:8], tbl[i].e_d1);
      next_cycle();
    end
    rst = 1'b0;
    drive_a(0, 0, 0, 8'h00, 2'b11);

    // out-of-range select on the 3-channel instance
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive_b(0, 1, 2'd3, 8'h77, 3'b111);
    @(negedge clk);
    chk("b_oor_in_ready", b_ir, 1'b1);
    next_cycle();
    drive_b(0, 0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    chk("b_oor_out_valid", b_ov, 3'b000);
    chk("b_oor_err_set", b_err, 1'b1);
    next_cycle();
    next_cycle();
    drive_b(0, 1, 2'd2, 8'h88, 3'b000);
    next_cycle();
    drive_b(0, 0, 2'd0, 8'h00, 3'b000);
    @(negedge clk);
    chk("b_oor_err_sticky", b_err, 1'b1);
    chk("b_after_oor_valid", b_ov, 3'b100);
    chk("b_after_oor_data2", b_od[23:16], 8'h88);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("b_err_cleared", b_err, 1'b0);
    chk("b_slots_cleared", b_ov, 3'b000);
    next_cycle();

    // random traffic against the model, with occasional resets
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive_b($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
              2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom_range(0, 7)));
      dest = b_auto ? m_ptr : int'(b_sel);
      e_ir = (dest >= NB) ? 1'b1 : (!m_full[dest] || b_rdy[dest]);
      @(negedge clk);
      chk("rnd_in_ready", b_ir, e_ir);
      chk("rnd_rr_ptr", b_rr, m_ptr);
      chk("rnd_err_sel", b_err, m_err);
      for (int k = 0; k < NB; k++) begin
        chk($sformatf("rnd_valid%0d", k), b_ov[k], m_full[k]);
        if (m_full[k]) chk($sformatf("rnd_data%0d", k), b_od[k*8 +: 8], m_data[k]);
      end
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (m_full[k] && b_rdy[k]) m_full[k] = 1'b0;
        end
        if (b_vld && e_ir) begin
          if (dest < NB) begin
            m_full[dest] = 1'b1;
            m_data[dest] = b_data;
          end else begin
            m_err = 1'b1;
          end
          if (b_auto) m_ptr = (m_ptr + 1) % NB;
        end
      end
      #1;
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
